// File: rtl/boron_pkg.sv
// Shared constants for the BORON core arbiter: widths, modes, FSM encoding
// and the two-way round-robin helper.
package boron_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic PORT_0 = 1'b0;
  localparam logic PORT_1 = 1'b1;

  localparam logic [BLOCK_W-1:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  // Arbiter FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  // Winner for a two-way round robin: the sole requester, or on a tie the
  // port that did not win last time. Only meaningful when valid != 0.
  function automatic logic rr_winner(input logic [1:0] valid, input logic last_grant);
    logic win;
    case (valid)
      2'b01:   win = PORT_0;
      2'b10:   win = PORT_1;
      2'b11:   win = ~last_grant;
      default: win = PORT_0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/boron_rr_pick.sv
// Combinational two-way round-robin pick for the BORON arbiter.
module boron_rr_pick
  import boron_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       any_valid,
  output logic       winner
);

  // Decide whether anyone is asking and which port wins
  always_comb begin
    any_valid = 1'b0;
    winner    = PORT_0;
    if (req_valid != 2'b00) begin
      any_valid = 1'b1;
      winner    = rr_winner(req_valid, last_grant);
    end else begin
      any_valid = 1'b0;
      winner    = PORT_0;
    end
  end

endmodule

// File: rtl/boron_core_arbiter.sv
// Shares one BORON cipher core between two requesters: round-robin grant,
// one-cycle start pulse, watchdog-guarded wait for done, and a held
// valid/ready response to the granted port.
module boron_core_arbiter
  import boron_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd96
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid_0,
  input  logic               req_valid_1,
  output logic               req_ready_0,
  output logic               req_ready_1,
  input  logic               req_mode_0,
  input  logic               req_mode_1,
  input  logic [BLOCK_W-1:0] req_data_0,
  input  logic [BLOCK_W-1:0] req_data_1,
  input  logic [KEY_W-1:0]   req_key_0,
  input  logic [KEY_W-1:0]   req_key_1,
  output logic               rsp_valid_0,
  output logic               rsp_valid_1,
  input  logic               rsp_ready_0,
  input  logic               rsp_ready_1,
  output logic [BLOCK_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic               core_start,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_data,
  output logic [KEY_W-1:0]   core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result
);

  logic [2:0] state_r;
  logic       last_grant_r;
  logic       grant_r;
  logic [7:0] wdog_r;

  logic [1:0] req_valid_s;
  logic       any_valid_s;
  logic       winner_s;
  logic       grant_now_s;
  logic       resp_take_s;
  logic       wdog_expire_s;

  assign req_valid_s = {req_valid_1, req_valid_0};

  boron_rr_pick u_rr_pick (
    .req_valid  (req_valid_s),
    .last_grant (last_grant_r),
    .any_valid  (any_valid_s),
    .winner     (winner_s)
  );

  // Accept a request only in IDLE; ready goes to the round-robin winner
  always_comb begin
    grant_now_s = 1'b0;
    req_ready_0 = 1'b0;
    req_ready_1 = 1'b0;
    if (!reset && (state_r == ST_IDLE) && any_valid_s) begin
      grant_now_s = 1'b1;
      req_ready_0 = (winner_s == PORT_0);
      req_ready_1 = (winner_s == PORT_1);
    end else begin
      grant_now_s = 1'b0;
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
    end
  end

  // Response handshake on the granted port only; the other ready is ignored
  always_comb begin
    resp_take_s = 1'b0;
    if (state_r == ST_RESP) begin
      resp_take_s = (grant_r == PORT_0) ? rsp_ready_0 : rsp_ready_1;
    end else begin
      resp_take_s = 1'b0;
    end
  end

  assign wdog_expire_s = (wdog_r == (TIMEOUT - 8'd1));

  // Arbiter FSM with latched core inputs, watchdog and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= PORT_1;
      grant_r      <= PORT_0;
      wdog_r       <= 8'd0;
      core_start   <= 1'b0;
      core_mode    <= MODE_ENC;
      core_data    <= {BLOCK_W{1'b0}};
      core_key     <= {KEY_W{1'b0}};
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
      rsp_data     <= {BLOCK_W{1'b0}};
      rsp_err      <= 1'b0;
    end else begin
      // Start is a single-cycle pulse raised only on the grant edge
      core_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_now_s) begin
            grant_r      <= winner_s;
            last_grant_r <= winner_s;
            core_mode    <= (winner_s == PORT_1) ? req_mode_1 : req_mode_0;
            core_data    <= (winner_s == PORT_1) ? req_data_1 : req_data_0;
            core_key     <= (winner_s == PORT_1) ? req_key_1  : req_key_0;
            core_start   <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_ARM;
        end
        ST_ARM: begin
          // core_done may still be high from the previous operation here
          wdog_r  <= 8'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            rsp_data    <= core_result;
            rsp_err     <= 1'b0;
            rsp_valid_0 <= (grant_r == PORT_0);
            rsp_valid_1 <= (grant_r == PORT_1);
            state_r     <= ST_RESP;
          end else if (wdog_expire_s) begin
            rsp_data    <= ERR_DATA;
            rsp_err     <= 1'b1;
            rsp_valid_0 <= (grant_r == PORT_0);
            rsp_valid_1 <= (grant_r == PORT_1);
            state_r     <= ST_RESP;
          end else begin
            wdog_r <= wdog_r + 8'd1;
          end
        end
        ST_RESP: begin
          if (resp_take_s) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_0 <= 1'b0;
          rsp_valid_1 <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boron_core_arbiter.sv
// Scoreboard bench for boron_core_arbiter with a behavioural core model.
module tb_boron_core_arbiter;
  import boron_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic        req_mode_0, req_mode_1;
  logic [63:0] req_data_0, req_data_1;
  logic [79:0] req_key_0, req_key_1;
  logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        core_start, core_mode;
  logic [63:0] core_data;
  logic [79:0] core_key;
  logic        core_done = 1'b0;
  logic [63:0] core_result = 64'h0;

  always #5 clk = ~clk;

  boron_core_arbiter #(.TIMEOUT(8'd96)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_mode_0(req_mode_0), .req_mode_1(req_mode_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .req_key_0(req_key_0), .req_key_1(req_key_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_mode(core_mode),
    .core_data(core_data), .core_key(core_key),
    .core_done(core_done), .core_result(core_result)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: accepts Start one cycle late, done after lat_cfg cycles,
  // done level held until the next accepted Start.
  logic        start_d = 1'b0;
  int          cnt = 0;
  int          lat_cfg = 50;
  bit          never_done = 1'b0;
  bit          use_fixed = 1'b0;
  logic [63:0] res_fixed = 64'h0;

  always @(posedge clk) begin
    start_d <= core_start;
    if (start_d) begin
      core_done <= 1'b0;
      cnt <= lat_cfg;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !never_done) begin
        core_done   <= 1'b1;
        core_result <= use_fixed ? res_fixed : ~core_data;
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Scoreboard
  typedef struct packed {logic [63:0] data; logic err;} rsp_t;
  rsp_t exp0_q[$];
  rsp_t exp1_q[$];
  int   exp_grant_q[$];
  rsp_t cur0, cur1;
  bit   cur0_ok = 1'b0, cur1_ok = 1'b0;
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;
  int   grant_cyc = 0, last_lat = -1, start_cnt = 0, rsp_done_cnt = 0;
  bit   bp_watch = 1'b0;
  int   g;

  // Monitor: samples just after the falling edge, pops and compares
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_v0 <= 1'b0;
      prev_v1 <= 1'b0;
    end else begin
      if (req_ready_0 && req_ready_1) fail_now("both_ready");
      if ((req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1)) begin
        grant_cyc <= cyc;
        if (exp_grant_q.size() == 0) fail_now("grant_unexpected");
        else begin
          g = exp_grant_q.pop_front();
          chk("grant_port", {79'd0, req_ready_1}, g[79:0]);
        end
      end
      if (core_start) begin
        start_cnt <= start_cnt + 1;
        chk("start_latency", 80'(cyc - grant_cyc), 80'd1);
      end
      if (rsp_valid_0 && rsp_valid_1) fail_now("both_rsp_valid");
      if (rsp_valid_0) begin
        if (!prev_v0) begin
          last_lat <= cyc - grant_cyc;
          if (exp0_q.size() == 0) begin
            fail_now("rsp0_unexpected");
            cur0_ok = 1'b0;
          end else begin
            cur0 = exp0_q.pop_front();
            cur0_ok = 1'b1;
          end
        end
        if (cur0_ok) begin
          chk("rsp0_data", {16'd0, rsp_data}, {16'd0, cur0.data});
          chk("rsp0_err", {79'd0, rsp_err}, {79'd0, cur0.err});
        end
        if (rsp_ready_0) rsp_done_cnt <= rsp_done_cnt + 1;
      end
      if (rsp_valid_1) begin
        if (!prev_v1) begin
          last_lat <= cyc - grant_cyc;
          if (exp1_q.size() == 0) begin
            fail_now("rsp1_unexpected");
            cur1_ok = 1'b0;
          end else begin
            cur1 = exp1_q.pop_front();
            cur1_ok = 1'b1;
          end
        end
        if (cur1_ok) begin
          chk("rsp1_data", {16'd0, rsp_data}, {16'd0, cur1.data});
          chk("rsp1_err", {79'd0, rsp_err}, {79'd0, cur1.err});
        end
        if (rsp_ready_1) rsp_done_cnt <= rsp_done_cnt + 1;
      end
      if (bp_watch) begin
        chk("bp_rsp_valid_0_held", {79'd0, rsp_valid_0}, 80'd1);
        chk("bp_req_ready_1_low", {79'd0, req_ready_1}, 80'd0);
      end
      prev_v0 <= rsp_valid_0;
      prev_v1 <= rsp_valid_1;
    end
  end

  task automatic send0(input logic m, input logic [63:0] d, input logic [79:0] k);
    int n = 0;
    @(negedge clk);
    req_valid_0 = 1'b1; req_mode_0 = m; req_data_0 = d; req_key_0 = k;
    #1;
    while (!req_ready_0 && n < 600) begin @(negedge clk); #1; n++; end
    if (!req_ready_0) fail_now("req0_accept_timeout");
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
  endtask

  task automatic send1(input logic m, input logic [63:0] d, input logic [79:0] k);
    int n = 0;
    @(negedge clk);
    req_valid_1 = 1'b1; req_mode_1 = m; req_data_1 = d; req_key_1 = k;
    #1;
    while (!req_ready_1 && n < 600) begin @(negedge clk); #1; n++; end
    if (!req_ready_1) fail_now("req1_accept_timeout");
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_done_cnt < target && n < 400) begin @(negedge clk); n++; end
    if (rsp_done_cnt < target) fail_now("rsp_wait_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready_0"}, {79'd0, req_ready_0}, 80'd0);
    chk({tag, "_req_ready_1"}, {79'd0, req_ready_1}, 80'd0);
    chk({tag, "_rsp_valid_0"}, {79'd0, rsp_valid_0}, 80'd0);
    chk({tag, "_rsp_valid_1"}, {79'd0, rsp_valid_1}, 80'd0);
    chk({tag, "_rsp_err"}, {79'd0, rsp_err}, 80'd0);
    chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 80'd0);
    chk({tag, "_core_start"}, {79'd0, core_start}, 80'd0);
    chk({tag, "_core_mode"}, {79'd0, core_mode}, 80'd0);
    chk({tag, "_core_data"}, {16'd0, core_data}, 80'd0);
    chk({tag, "_core_key"}, core_key, 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  int base;
  int sbase;

  initial begin
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_mode_0 = 1'b0; req_mode_1 = 1'b0;
    req_data_0 = 64'h0; req_data_1 = 64'h0;
    req_key_0 = 80'h0; req_key_1 = 80'h0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Single encrypt on port 0 with a fixed core result after 50 cycles
    use_fixed = 1'b1; res_fixed = 64'hDEAD_BEEF_0000_0001; lat_cfg = 50;
    sbase = start_cnt; base = rsp_done_cnt;
    exp_grant_q.push_back(0);
    exp0_q.push_back('{data: 64'hDEAD_BEEF_0000_0001, err: 1'b0});
    send0(MODE_ENC, 64'h0123_4567_89AB_CDEF, 80'h0);
    chk("t1_core_start", {79'd0, core_start}, 80'd1);
    chk("t1_core_data", {16'd0, core_data}, {16'd0, 64'h0123_4567_89AB_CDEF});
    wait_rsp(base + 1);
    chk("t1_rsp_latency", 80'(last_lat), 80'd54);
    chk("t1_start_pulses", 80'(start_cnt - sbase), 80'd1);
    use_fixed = 1'b0;

    // Reset during WAIT on a port-0 decrypt
    lat_cfg = 30;
    exp_grant_q.push_back(0);
    send0(MODE_DEC, 64'h5555_5555_5555_5555, 80'h1234);
    chk("rst_core_mode", {79'd0, core_mode}, 80'd1);
    chk("rst_core_key", core_key, 80'h1234);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #3;
    check_reset_outputs("midrst");
    reset = 1'b0;

    // Tie right after reset: port 0 first, then port 1
    lat_cfg = 8; base = rsp_done_cnt;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    exp0_q.push_back('{data: 64'hFEDC_BA98_7654_3210, err: 1'b0});
    exp1_q.push_back('{data: 64'hEEEE_DDDD_CCCC_BBBB, err: 1'b0});
    fork
      send0(MODE_ENC, 64'h0123_4567_89AB_CDEF, 80'h1);
      send1(MODE_DEC, 64'h1111_2222_3333_4444, 80'h2);
    join
    wait_rsp(base + 2);

    // Both held valid: grants alternate 0,1,0,1
    base = rsp_done_cnt;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    exp0_q.push_back('{data: 64'hFFFF_FFFF_FFFF_FF00, err: 1'b0});
    exp0_q.push_back('{data: 64'h0F0F_0F0F_F0F0_F0F0, err: 1'b0});
    exp1_q.push_back('{data: 64'h5555_5555_FFFF_FFFF, err: 1'b0});
    exp1_q.push_back('{data: 64'h7FFF_FFFF_FFFF_FFFE, err: 1'b0});
    fork
      begin
        send0(MODE_ENC, 64'h0000_0000_0000_00FF, 80'h3);
        send0(MODE_ENC, 64'hF0F0_F0F0_0F0F_0F0F, 80'h4);
      end
      begin
        send1(MODE_DEC, 64'hAAAA_AAAA_0000_0000, 80'h5);
        send1(MODE_DEC, 64'h8000_0000_0000_0001, 80'h6);
      end
    join
    wait_rsp(base + 4);

    // Stale done still high from the previous op; only the fresh done counts
    lat_cfg = 10; base = rsp_done_cnt;
    exp_grant_q.push_back(1);
    exp1_q.push_back('{data: 64'hF0F0_F0F0_F0F0_F0F0, err: 1'b0});
    send1(MODE_ENC, 64'h0F0F_0F0F_0F0F_0F0F, 80'h7);
    wait_rsp(base + 1);

    // Core never finishes: watchdog abort at grant+99
    never_done = 1'b1; base = rsp_done_cnt;
    exp_grant_q.push_back(0);
    exp0_q.push_back('{data: ERR_DATA, err: 1'b1});
    send0(MODE_ENC, 64'h1234_5678_9ABC_DEF0, 80'h8);
    wait_rsp(base + 1);
    chk("wdog_latency", 80'(last_lat), 80'd99);
    never_done = 1'b0;

    // Done in the same cycle the watchdog expires: done wins
    lat_cfg = 95; base = rsp_done_cnt;
    exp_grant_q.push_back(1);
    exp1_q.push_back('{data: 64'h0000_FFFF_0000_FFFF, err: 1'b0});
    send1(MODE_ENC, 64'hFFFF_0000_FFFF_0000, 80'h9);
    wait_rsp(base + 1);
    chk("edge_done_latency", 80'(last_lat), 80'd99);

    // Done one cycle too late: abort
    lat_cfg = 96; base = rsp_done_cnt;
    exp_grant_q.push_back(0);
    exp0_q.push_back('{data: ERR_DATA, err: 1'b1});
    send0(MODE_ENC, 64'h0, 80'hA);
    wait_rsp(base + 1);
    chk("late_done_latency", 80'(last_lat), 80'd99);

    // Back-pressure on port 0 while port 1 waits
    lat_cfg = 10; base = rsp_done_cnt;
    rsp_ready_0 = 1'b0;
    exp_grant_q.push_back(0); exp_grant_q.push_back(1);
    exp0_q.push_back('{data: 64'hFFFF_0000_FFFF_0000, err: 1'b0});
    exp1_q.push_back('{data: 64'hDB97_531F_ECA8_6420, err: 1'b0});
    fork
      send0(MODE_ENC, 64'h0000_FFFF_0000_FFFF, 80'hB);
      begin
        repeat (3) @(negedge clk);
        send1(MODE_ENC, 64'h2468_ACE0_1357_9BDF, 80'hC);
      end
      begin
        int n = 0;
        while (!rsp_valid_0 && n < 300) begin @(negedge clk); n++; end
        if (!rsp_valid_0) fail_now("bp_rsp_wait_timeout");
        bp_watch = 1'b1;
        repeat (20) @(negedge clk);
        bp_watch = 1'b0;
        rsp_ready_0 = 1'b1;
      end
    join
    wait_rsp(base + 2);
    chk("exp_queues_drained", 80'(exp0_q.size() + exp1_q.size() + exp_grant_q.size()), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
